fifo_ser_tx: RTL and testbench
==============================

// Module: fifo_ser_tx
// PURPOSE
//  Downstream drain stage for the 16-bit word FIFO. Pops one word at a time with
//  a single-cycle get strobe and sends it as an asynchronous serial frame on tx.
//  The FIFO exports no status flags, so this block keeps a shadow occupancy count.
//  It builds that count by watching the FIFO put strobe and its own get strobe.
// PARAMETERS
//  DATA_W        16  word width; must equal the FIFO word width
//  DEPTH         8   FIFO depth; upper bound of the shadow count
//  CNT_W         4   shadow counter width; must satisfy 2**CNT_W > DEPTH
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range 2..255
//  DIV_W         8   bit-timer width
// PORTS
//  clk       in   1       rising-edge clock, shared with the FIFO
//  reset     in   1       synchronous reset, active-high
//  put_mon   in   1       copy of the FIFO put strobe
//  tx_en     in   1       1 = may start new frames; 0 = finish current frame, then hold
//  data_in   in   DATA_W  FIFO data_out; this is the combinational FIFO head word
//  get       out  1       FIFO get strobe; high for one cycle per popped word
//  tx        out  1       serial line; idle level is 1
//  busy      out  1       high from LOAD through the last STOP cycle
//  occ       out  CNT_W   shadow FIFO occupancy
// BEHAVIOUR
//  Reset
//   - Reset is synchronous and active-high. It wins over every other input.
//   - Reset values: tx=1, get=0, busy=0, occ=0, state=IDLE, bit timer=0.
//   - Mid-frame reset: the frame aborts and tx=1 from the next edge.
//   - The FIFO must be cleared in the same cycle (system rule) to keep occ coherent.
//  Shadow count (occ), per cycle, from {put_mon,get}
//   - 10: occ+1 if occ<DEPTH; otherwise unchanged, because the FIFO drops the word.
//   - 01: occ-1.
//   - 11: occ unchanged.
//   - 00: occ unchanged.
//   - get is only ever asserted when occ>0, so occ never underflows.
//  State machine: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP
//   - IDLE: tx=1. Go to LOAD when tx_en=1 and occ>0.
//   - LOAD (one cycle): get=1.
//     - shreg <= data_in, which is the head word before the FIFO pointer advances.
//     - Go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: tx=shreg[0], LSB first.
//     - Each bit lasts CLKS_PER_BIT cycles, then shreg shifts right.
//     - Leave after DATA_W bits, tracked by a bit index counter.
//   - STOP: tx=1 for CLKS_PER_BIT cycles.
//     - At the end: go to LOAD if tx_en=1 and occ>0 (occ as updated that cycle); else IDLE.
//  Timing
//   - Bit timer counts 0..CLKS_PER_BIT-1 and gives a tick on the last count.
//   - State advances only on a tick, except in IDLE and LOAD.
//   - Frame length = (2+DATA_W)*CLKS_PER_BIT cycles; the optional parity bit adds CLKS_PER_BIT.
//   - Back-to-back words have exactly one idle-level LOAD cycle between frames.
//  Boundary cases
//   - tx_en falls mid-frame: the frame completes, then the FSM returns to IDLE.
//   - put_mon arrives in the same cycle as get: occ is unchanged.
//   - put_mon at occ==DEPTH with no get: occ stays at DEPTH.
// CONFIGURATION
//  FIFO_SER_TX_PARITY_EN
//   - Defined: an extra PARITY state sits between DATA and STOP.
//     - tx = even parity, i.e. the XOR of the word, held for CLKS_PER_BIT cycles.
//     - Parity is computed at LOAD.
//   - Undefined: DATA goes straight to STOP, and no parity logic is built.
// STRUCTURE
//  Package fifo_ser_pkg
//   - State encoding constants: IDLE, LOAD, START, DATA, PARITY, STOP.
//   - Frame-length constant FRAME_BITS: 2+DATA_W, or 3+DATA_W with parity.
//  Sub-module ser_bit_timer
//   - Divider counter with a tick output.
//   - Cleared on reset and on entry to START.
// TESTING (CLKS_PER_BIT=4, DATA_W=16, DEPTH=8)
//  1. Reset, idle: reset for 2 cycles, then hold all inputs low.
//     -> tx=1, get=0, busy=0, occ=0 for 20 cycles.
//  2. One word: one put_mon with data_in=16'hA5C3, tx_en=1.
//     -> Exactly one get; frame = 0, bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1.
//     -> 72 cycles of frame; occ returns to 0.
//  3. Occupancy: 9 put_mon with tx_en=0 -> occ saturates at 8.
//     -> Then tx_en=1: 8 frames with a 1-cycle gap between them, then IDLE.
//  4. Simultaneous events: put_mon in the LOAD cycle -> occ unchanged that cycle.
//  5. Reset mid-frame: reset during DATA bit 5.
//     -> tx=1 the next cycle, occ=0, no further get.
//  6. With FIFO_SER_TX_PARITY_EN, word 16'h0001.
//     -> Parity bit = 1, frame = 76 cycles.
//     -> Same bench without the macro: 72 cycles.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and frame constants for the FIFO serial drain stage.
// Optional parity frame bit is selected by FIFO_SER_TX_PARITY_EN.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam int WORD_W = 16;

`ifdef FIFO_SER_TX_PARITY_EN
  localparam int FRAME_BITS = 3 + WORD_W;
`else
  localparam int FRAME_BITS = 2 + WORD_W;
`endif

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last count.
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == DIV_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ser_tx.sv
// Pops words from a flagless FIFO (tracking a shadow occupancy) and sends them LSB-first
// as start/data/stop frames on tx. Define FIFO_SER_TX_PARITY_EN for an even-parity bit.
module fifo_ser_tx
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              put_mon,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              get,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  occ
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  occ_nxt;
  logic              tick;
  logic              tmr_clr;
`ifdef FIFO_SER_TX_PARITY_EN
  logic              par_bit;
`endif

  // LOAD always precedes START, so clearing here aligns the first tick with the START bit.
  assign tmr_clr = (state == LOAD);

  ser_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DIV_W        (DIV_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .tick  (tick)
  );

  // A put at full occupancy is dropped by the FIFO, so the count saturates at DEPTH.
  always_comb begin
    occ_nxt = occ;
    case ({put_mon, get})
      2'b10:   if (occ < CNT_W'(DEPTH)) occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      occ <= occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= data_in;
`ifdef FIFO_SER_TX_PARITY_EN
      par_bit <= ^data_in;
`endif
    end else if (state == DATA && tick) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      get     <= 1'b0;
      busy    <= 1'b0;
      bit_idx <= '0;
    end else begin
      get <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_en && occ != '0) begin
            state <= LOAD;
            get   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state   <= START;
          tx      <= 1'b0;
          bit_idx <= '0;
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef FIFO_SER_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef FIFO_SER_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Decision uses this cycle's updated occupancy so a same-cycle put chains a frame.
          if (tick) begin
            if (tx_en && occ_nxt != '0) begin
              state <= LOAD;
              get   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ser_tx.sv
// Bench for fifo_ser_tx: a queue-based FIFO model plus a frame receiver check every cycle.
module tb_fifo_ser_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CPB   = 4;
`ifdef FIFO_SER_TX_PARITY_EN
  localparam int FB = DW + 3;
`else
  localparam int FB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          put_mon = 1'b0;
  logic          tx_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          get, tx, busy;
  logic [CW-1:0] occ;

  always #5 clk = ~clk;

  fifo_ser_tx #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .CNT_W        (CW),
    .CLKS_PER_BIT (CPB),
    .DIV_W        (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .put_mon (put_mon),
    .tx_en   (tx_en),
    .data_in (data_in),
    .get     (get),
    .tx      (tx),
    .busy    (busy),
    .occ     (occ)
  );

  typedef struct {
    logic       r;
    logic       p;
    logic       en;
    logic [3:0] occ;
    logic       tx;
    logic       get;
    logic       busy;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] popped[$];
  bit            chk_en = 0;
  bit            rx_active = 0;
  int            rx_cnt = 0;
  int            rx_bad = 0;
  logic [DW-1:0] rx_exp = '0;
  int            frames = 0;
  int            cyc_no = 0;
  int            last_stop = -100;
  int            gap1 = 0;
  int            gets = 0;
  int            busy_cycles = 0;
  bit            pend_start = 0;
  bit            done_flag;
  vec_t          tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Expected line level for frame bit b of word w.
  function automatic logic exp_bit(input int b, input logic [DW-1:0] w);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
`ifdef FIFO_SER_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Check outputs of the cycle just finished, then drive the next cycle and advance the model.
  task automatic cyc(input logic r, input logic p, input logic [DW-1:0] w, input logic en);
    int sz;
    if (chk_en) begin
      sz = fifo_q.size();
      check("occ", 32'(occ), 32'(sz));
      if (pend_start) check("start_latency", 32'(busy), 1);
      if (get === 1'b1) begin
        gets++;
        check("get_nonempty", 32'(sz > 0), 1);
      end
      if (busy === 1'b1) busy_cycles++;
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1;
        rx_cnt = 0;
        rx_bad = 0;
        check("frame_has_word", 32'(popped.size() > 0), 1);
        if (popped.size() > 0) rx_exp = popped.pop_front();
        if (cyc_no - last_stop == 2) gap1++;
      end
      check("busy", 32'(busy), 32'(get === 1'b1 || rx_active));
      if (rx_active) begin
        if (tx !== exp_bit(rx_cnt / CPB, rx_exp)) rx_bad++;
        rx_cnt++;
        if (rx_cnt == FB * CPB) begin
          rx_active = 0;
          frames++;
          last_stop = cyc_no;
          check("frame_bits", 32'(rx_bad), 0);
        end
      end
    end
    reset   = r;
    put_mon = p;
    tx_en   = en;
    data_in = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    pend_start = chk_en && !r && en && busy === 1'b0 && get === 1'b0 && fifo_q.size() > 0;
    if (get === 1'b1 && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
    if (p && fifo_q.size() < DEPTH) fifo_q.push_back(w);
    if (r) begin
      fifo_q.delete();
      popped.delete();
      rx_active = 0;
      pend_start = 0;
    end
    @(negedge clk);
    cyc_no++;
    if (r) chk_en = 1;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      if (busy === 1'b0 && fifo_q.size() == 0 && !rx_active) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //                r     p     en    occ   tx    get   busy
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      tbl[3+i] = '{1'b0, 1'b1, 1'b0, (i < 8) ? 4'(i + 1) : 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1};

    // Reset then quiet idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0);
      check("idle_tx", 32'(tx), 1);
      check("idle_get", 32'(get), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_occ", 32'(occ), 0);
    end

    // Single word A5C3
    do_reset();
    frames = 0; gets = 0; busy_cycles = 0;
    cyc(1'b0, 1'b1, 16'hA5C3, 1'b1);
    wait_idle(400);
    check("one_word_frames", 32'(frames), 1);
    check("one_word_gets", 32'(gets), 1);
    check("one_word_busy_len", 32'(busy_cycles), 32'(1 + FB * CPB));
    check("one_word_value", 32'(rx_exp), 32'h0000_A5C3);
    check("one_word_occ", 32'(occ), 0);

    // Occupancy saturation, then eight back-to-back frames
    frames = 0; gap1 = 0; last_stop = -100;
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].r, tbl[i].p, 16'($urandom), tbl[i].en);
      check("tbl_occ", 32'(occ), 32'(tbl[i].occ));
      check("tbl_tx", 32'(tx), 32'(tbl[i].tx));
      check("tbl_get", 32'(get), 32'(tbl[i].get));
      check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
    end
    wait_idle(2000);
    check("sat_frames", 32'(frames), 8);
    check("sat_gaps", 32'(gap1), 7);

    // Put coinciding with the LOAD-cycle get
    cyc(1'b0, 1'b1, 16'h1234, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("coinc_get", 32'(get), 1);
    check("coinc_occ_before", 32'(occ), 1);
    cyc(1'b0, 1'b1, 16'h5678, 1'b1);
    check("coinc_occ_after", 32'(occ), 1);
    wait_idle(400);

    // Reset in the middle of data bit 5
    do_reset();
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
    done_flag = 0;
    for (int i = 0; i < 200; i++) begin
      if (rx_active && rx_cnt == 6 * CPB + 2) begin
        done_flag = 1;
        break;
      end
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    check("midreset_reached", 32'(done_flag), 1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    check("midreset_tx", 32'(tx), 1);
    check("midreset_occ", 32'(occ), 0);
    check("midreset_busy", 32'(busy), 0);
    gets = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      check("midreset_line", 32'(tx), 1);
    end
    check("midreset_gets", 32'(gets), 0);

    // Word 0001: frame length depends on the parity build
    do_reset();
    frames = 0; busy_cycles = 0;
    cyc(1'b0, 1'b1, 16'h0001, 1'b1);
    wait_idle(400);
    check("w0001_frames", 32'(frames), 1);
    check("w0001_busy_len", 32'(busy_cycles), 32'(1 + FB * CPB));

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom), ((i % 400) < 300));
    end
    wait_idle(3000);
    check("rand_popped_empty", 32'(popped.size()), 0);
    check("rand_occ_final", 32'(occ), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
